// File: rtl/lcd_timing_gen.sv
// Parallel-bus LCD timing generator: raster counters, early pixel request with coordinates,
// sub-pixel serialiser and sync/DE delay pipeline matched to the pixel fetch latency.
module lcd_timing_gen #(
  parameter int unsigned H_VISIBLE     = 320,
  parameter int unsigned H_FRONT       = 20,
  parameter int unsigned H_SYNC        = 30,
  parameter int unsigned H_BACK        = 38,
  parameter int unsigned V_VISIBLE     = 240,
  parameter int unsigned V_FRONT       = 4,
  parameter int unsigned V_SYNC        = 3,
  parameter int unsigned V_BACK        = 15,
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned CH_WIDTH      = 8,
  parameter int unsigned FETCH_LATENCY = 0,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter bit          DE_POL        = 1'b0,
  parameter int unsigned X_W           = 10,
  parameter int unsigned Y_W           = 10
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  output logic                         pix_req,
  output logic [X_W-1:0]               pix_x,
  output logic [Y_W-1:0]               pix_y,
  input  logic [CHANNELS*CH_WIDTH-1:0] pix_data,
  output logic [CH_WIDTH-1:0]          lcd_dat,
  output logic                         lcd_hsync,
  output logic                         lcd_vsync,
  output logic                         lcd_den,
  output logic                         frame_start,
  output logic [15:0]                  frame_count,
  output logic                         busy
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned Lat    = FETCH_LATENCY;
  localparam int unsigned ReqW   = (Lat == 0) ? 1 : Lat;
  localparam int unsigned PixW   = CHANNELS * CH_WIDTH;

  localparam logic [X_W-1:0] HVis     = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] HSyncOn  = X_W'(H_VISIBLE + H_FRONT);
  localparam logic [X_W-1:0] HSyncOff = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [X_W-1:0] HLast    = X_W'(HTotal - 1);
  localparam logic [Y_W-1:0] VVis     = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] VSyncOn  = Y_W'(V_VISIBLE + V_FRONT);
  localparam logic [Y_W-1:0] VSyncOff = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [Y_W-1:0] VLast    = Y_W'(VTotal - 1);
  localparam logic [1:0]     SlotLast = 2'(CHANNELS - 1);

  typedef enum logic [1:0] {StStopped, StRunning, StDraining} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [X_W-1:0]   h_q, h_d;
  logic [Y_W-1:0]   v_q, v_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [Lat:0]     hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [ReqW-1:0]  req_q, req_d;
  logic [PixW-1:0]  hold_q, hold_d;
  logic [1:0]       sh_q, sh_d;
  logic [CH_WIDTH-1:0] dat_q, dat_d;

  logic run, wrap, vis, hs_raw, vs_raw, ld;

  always_comb begin
    run         = (state_q != StStopped);
    wrap        = run && (slot_q == SlotLast) && (h_q == HLast) && (v_q == VLast);
    vis         = run && (h_q < HVis) && (v_q < VVis);
    hs_raw      = run && (h_q >= HSyncOn) && (h_q < HSyncOff);
    vs_raw      = run && (v_q >= VSyncOn) && (v_q < VSyncOff);
    pix_req     = vis && (slot_q == 2'd0);
    pix_x       = pix_req ? h_q : '0;
    pix_y       = pix_req ? v_q : '0;
    frame_start = run && (slot_q == 2'd0) && (h_q == '0) && (v_q == '0);
    busy        = run;
  end

  // A drop of enable only takes effect at the frame-wrap edge, so frames are never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStopped:  if (enable) state_d = StRunning;
      StRunning:  if (!enable) state_d = wrap ? StStopped : StDraining;
      StDraining: begin
        if (enable)    state_d = StRunning;
        else if (wrap) state_d = StStopped;
      end
      default:    state_d = StStopped;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    h_d    = h_q;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    if (run) begin
      if (slot_q == SlotLast) begin
        slot_d = 2'd0;
        if (h_q == HLast) begin
          h_d = '0;
          v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end else begin
        slot_d = slot_q + 2'd1;
      end
      if (wrap) fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_comb begin
    hs_d     = hs_q << 1;
    hs_d[0]  = hs_raw;
    vs_d     = vs_q << 1;
    vs_d[0]  = vs_raw;
    de_d     = de_q << 1;
    de_d[0]  = vis;
    req_d    = req_q << 1;
    req_d[0] = pix_req;
    // pix_data is valid on the cycle that is Lat clocks after the request.
    ld       = (Lat == 0) ? pix_req : req_q[ReqW-1];

    hold_d = hold_q;
    sh_d   = sh_q;
    dat_d  = '0;
    if (ld) begin
      dat_d  = pix_data[PixW-1 -: CH_WIDTH];
      hold_d = pix_data << CH_WIDTH;
      sh_d   = SlotLast;
    end else if (sh_q != 2'd0) begin
      dat_d  = hold_q[PixW-1 -: CH_WIDTH];
      hold_d = hold_q << CH_WIDTH;
      sh_d   = sh_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StStopped;
      slot_q  <= 2'd0;
      h_q     <= '0;
      v_q     <= '0;
      fcnt_q  <= 16'd0;
      hs_q    <= '0;
      vs_q    <= '0;
      de_q    <= '0;
      req_q   <= '0;
      hold_q  <= '0;
      sh_q    <= 2'd0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fcnt_q  <= fcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
    end
  end

  assign lcd_dat     = dat_q;
  assign lcd_hsync   = hs_q[Lat] ? HSYNC_POL : ~HSYNC_POL;
  assign lcd_vsync   = vs_q[Lat] ? VSYNC_POL : ~VSYNC_POL;
  assign lcd_den     = de_q[Lat] ? DE_POL : ~DE_POL;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default, single-channel/inverted-polarity and small-raster
// latency-2 instances against constant tables and an arithmetic raster model.
module tb_lcd_timing_gen;

  localparam int LHV = 8, LHF = 2, LHS = 3, LHB = 2;
  localparam int LVV = 8, LVF = 1, LVS = 2, LVB = 1;
  localparam int LC = 3, LL = 2;
  localparam int LHT = LHV + LHF + LHS + LHB;
  localparam int LVT = LVV + LVF + LVS + LVB;
  localparam int LFC = LC * LHT * LVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, en_def, en_lat;
  int   cyc;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= -1;
    else         cyc <= cyc + 1;
  end

  logic        def_req, def_hs, def_vs, def_de, def_fs, def_busy;
  logic [9:0]  def_x, def_y;
  logic [23:0] pd_def;
  logic [7:0]  def_dat;
  logic [15:0] def_fc;

  logic        one_req, one_hs, one_vs, one_de, one_fs, one_busy;
  logic [9:0]  one_x, one_y;
  logic [15:0] pd_one, one_dat, one_fc;

  logic        lat_req, lat_hs, lat_vs, lat_de, lat_fs, lat_busy;
  logic [9:0]  lat_x, lat_y;
  logic [23:0] pd_lat, src1, src2;
  logic [7:0]  lat_dat;
  logic [15:0] lat_fc;

  lcd_timing_gen u_def (
    .clk(clk), .resetn(resetn), .enable(en_def), .pix_req(def_req), .pix_x(def_x),
    .pix_y(def_y), .pix_data(pd_def), .lcd_dat(def_dat), .lcd_hsync(def_hs),
    .lcd_vsync(def_vs), .lcd_den(def_de), .frame_start(def_fs), .frame_count(def_fc),
    .busy(def_busy)
  );

  lcd_timing_gen #(.CHANNELS(1), .CH_WIDTH(16), .HSYNC_POL(1'b1), .DE_POL(1'b1)) u_one (
    .clk(clk), .resetn(resetn), .enable(en_def), .pix_req(one_req), .pix_x(one_x),
    .pix_y(one_y), .pix_data(pd_one), .lcd_dat(one_dat), .lcd_hsync(one_hs),
    .lcd_vsync(one_vs), .lcd_den(one_de), .frame_start(one_fs), .frame_count(one_fc),
    .busy(one_busy)
  );

  lcd_timing_gen #(
    .H_VISIBLE(LHV), .H_FRONT(LHF), .H_SYNC(LHS), .H_BACK(LHB),
    .V_VISIBLE(LVV), .V_FRONT(LVF), .V_SYNC(LVS), .V_BACK(LVB),
    .CHANNELS(LC), .FETCH_LATENCY(LL)
  ) u_lat (
    .clk(clk), .resetn(resetn), .enable(en_lat), .pix_req(lat_req), .pix_x(lat_x),
    .pix_y(lat_y), .pix_data(pd_lat), .lcd_dat(lat_dat), .lcd_hsync(lat_hs),
    .lcd_vsync(lat_vs), .lcd_den(lat_de), .frame_start(lat_fs), .frame_count(lat_fc),
    .busy(lat_busy)
  );

  // Pixel source with a two-clock fetch; junk on every other cycle exposes misalignment.
  always @(posedge clk) begin
    src1 <= lat_req ? {lat_x[7:0], lat_y[7:0], 8'hA5} : 24'($urandom);
    src2 <= src1;
  end
  assign pd_lat = src2;

  typedef struct packed {
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic [7:0]  dat;
    logic        hs;
    logic        vs;
    logic        de;
    logic        busy;
    logic [15:0] fc;
  } obs_t;

  obs_t lat_obs;
  assign lat_obs = {lat_req, lat_x, lat_y, lat_fs, lat_dat, lat_hs, lat_vs, lat_de, lat_busy,
                    lat_fc};

  // Expected small-raster outputs k cycles after the first counted cycle, stopping after
  // fstop complete frames.
  function automatic obs_t model(input int k, input int fstop);
    obs_t o;
    int   t, s, p, h, v;
    logic vis_t;
    o      = '0;
    o.busy = (k < fstop * LFC);
    o.fc   = 16'(o.busy ? k / LFC : fstop);
    if (o.busy) begin
      s     = k % LC;
      p     = k / LC;
      h     = p % LHT;
      v     = (p / LHT) % LVT;
      o.req = (s == 0) && (h < LHV) && (v < LVV);
      if (o.req) begin
        o.x = 10'(h);
        o.y = 10'(v);
      end
      o.fs = (k % LFC) == 0;
    end
    t    = k - LL - 1;
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.de = 1'b1;
    if (t >= 0 && t < fstop * LFC) begin
      s     = t % LC;
      p     = t / LC;
      h     = p % LHT;
      v     = (p / LHT) % LVT;
      vis_t = (h < LHV) && (v < LVV);
      o.de  = !vis_t;
      if (vis_t) o.dat = (s == 0) ? 8'(h) : (s == 1) ? 8'(v) : 8'hA5;
      o.hs = !(h >= LHV + LHF && h < LHV + LHF + LHS);
      o.vs = !(v >= LVV + LVF && v < LVV + LVF + LVS);
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return def_hs;
      1:       return one_hs;
      2:       return one_de;
      default: return def_req;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic lvl, output int t);
    int n = 0;
    while (sig(sel) !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== lvl) begin
      total++;
      bad++;
      $display("FAIL wait_sel%0d: level %0b not seen within 3000 clocks", sel, lvl);
    end
    t = cyc;
  endtask

  // Called at the negedge of counted cycle 0; random enable dips avoid every frame wrap.
  task automatic run_lat(input int ncyc, input int fstop, input bit drops);
    int   ws[16], wl[16];
    int   f, pos;
    obs_t exp;
    for (int i = 0; i < 16; i++) begin
      ws[i] = 10 + int'($urandom_range(389, 0));
      wl[i] = 1 + int'($urandom_range(99, 0));
    end
    for (int k = 0; k < ncyc; k++) begin
      exp = model(k, fstop);
      chk($sformatf("lat_k%0d", k), 64'(lat_obs), 64'(exp));
      f   = k / LFC;
      pos = k % LFC;
      en_lat = 1'b1;
      if (drops && f < 16 && pos >= ws[f] && pos < ws[f] + wl[f]) en_lat = 1'b0;
      if (fstop < 1000 && k >= (fstop - 1) * LFC + 5 * LC * LHT) en_lat = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [23:0] pd;
    logic [7:0]  b0, b1, b2;
  } vec_t;

  vec_t vecs[5];
  int   t0, t1, t2, t3, t4, errs, n;

  initial begin
    vecs[0] = '{24'h123456, 8'h12, 8'h34, 8'h56};
    vecs[1] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[2] = '{24'h000000, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{24'hA5C30F, 8'hA5, 8'hC3, 8'h0F};
    vecs[4] = '{24'h800001, 8'h80, 8'h00, 8'h01};

    resetn = 1'b1;
    en_def = 1'b0;
    en_lat = 1'b0;
    pd_def = '0;
    pd_one = 16'($urandom) | 16'h0001;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_def_ctl", {def_req, def_fs, def_busy, def_hs, def_vs, def_de}, 6'b000111);
    chk("rst_def_dat", {def_dat, def_x, def_y, def_fc}, '0);
    chk("rst_one_ctl", {one_req, one_fs, one_busy, one_hs, one_vs, one_de}, 6'b000010);
    chk("rst_one_dat", {one_dat, one_x, one_y, one_fc}, '0);
    chk("rst_lat", 64'(lat_obs), 64'({1'b0, 20'd0, 1'b0, 8'd0, 3'b111, 1'b0, 16'd0}));

    resetn = 1'b1;
    en_def = 1'b1;

    // Table-driven slice order on the first pixels of line 0, L=0.
    wait_level(3, 1'b1, t0);
    chk("def_first_req", {def_fs, def_x, def_y}, {1'b1, 20'd0});
    pd_def = vecs[0].pd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_b0", i), {def_de, def_dat}, {1'b0, vecs[i].b0});
      @(negedge clk);
      chk($sformatf("vec%0d_b1", i), {def_de, def_dat}, {1'b0, vecs[i].b1});
      @(negedge clk);
      chk($sformatf("vec%0d_b2", i), {def_de, def_dat}, {1'b0, vecs[i].b2});
      chk($sformatf("vec%0d_next_x", i), {def_req, def_x}, {1'b1, 10'(i + 1)});
      if (i < 4) pd_def = vecs[i + 1].pd;
    end

    // Default raster hsync timing.
    wait_level(0, 1'b0, t1);
    chk("def_hs_first_fall", t1, 1 + 340 * 3);
    chk("def_blank_dat", {def_de, def_dat}, {1'b1, 8'h00});
    wait_level(0, 1'b1, t2);
    wait_level(0, 1'b0, t3);
    chk("def_hs_width", t2 - t1, 90);
    chk("def_hs_period", t3 - t1, 1224);

    // Single-channel, active-high hsync and DE.
    wait_level(1, 1'b0, t0);
    wait_level(1, 1'b1, t1);
    wait_level(1, 1'b0, t2);
    wait_level(1, 1'b1, t3);
    chk("one_hs_width", t2 - t1, 30);
    chk("one_hs_period", t3 - t1, 408);
    wait_level(2, 1'b0, t0);
    wait_level(2, 1'b1, t1);
    errs = 0;
    n    = 0;
    while (one_de === 1'b1 && n < 1000) begin
      if (one_dat !== pd_one) errs++;
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    chk("one_de_data_errs", errs, 0);
    chk("one_de_width", t2 - t1, 320);
    chk("one_blank_dat", one_dat, 16'h0000);
    wait_level(1, 1'b1, t4);
    chk("one_de_to_hs", t4 - t2, 20);

    // Latency-2 raster: four frames with random enable dips, stop in the fourth, then idle.
    en_lat = 1'b1;
    @(negedge clk);
    run_lat(4 * LFC + 40, 4, 1'b1);

    en_lat = 1'b1;
    @(negedge clk);
    chk("restart_first", {lat_fs, lat_req, lat_x, lat_y, lat_busy, lat_fc},
        {1'b1, 1'b1, 20'd0, 1'b1, 16'd4});
    @(negedge clk);
    chk("restart_fs_pulse", lat_fs, 1'b0);
    repeat (20) @(negedge clk);

    #2 resetn = 1'b0;
    #1;
    chk("midreset_lat", 64'(lat_obs), 64'({1'b0, 20'd0, 1'b0, 8'd0, 3'b111, 1'b0, 16'd0}));
    chk("midreset_def", {def_hs, def_de, def_busy, def_dat}, {3'b110, 8'h00});
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_lat(LFC + 20, 1000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised successor to the badge's serial-RGB LCD timing generator.
- Generates hsync, vsync and data-enable for a parallel-bus LCD, and serialises each pixel as CHANNELS sub-pixel bytes (MSB slice first).
- Issues an early pixel request with coordinates so the framebuffer or waterfall source can return data with a fixed FETCH_LATENCY. Sync and DE outputs are delayed to match.
- Adds an enable with a clean end-of-frame stop, programmable sync/DE polarity, and a frame counter.

Parameters:
- H_VISIBLE, 320, visible pixels per line
- H_FRONT, 20, horizontal front porch (pixels)
- H_SYNC, 30, hsync width (pixels)
- H_BACK, 38, horizontal back porch (pixels)
- V_VISIBLE, 240, visible lines
- V_FRONT, 4, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BACK, 15, vertical back porch (lines)
- CHANNELS, 3, clocks per pixel / sub-pixel slices (1..4)
- CH_WIDTH, 8, bits per slice and width of lcd_dat
- FETCH_LATENCY, 0, clocks from pix_req to pix_data valid (0..3)
- HSYNC_POL, 0, active level of lcd_hsync
- VSYNC_POL, 0, active level of lcd_vsync
- DE_POL, 0, active level of lcd_den
- X_W, 10, width of x coordinate/counter
- Y_W, 10, width of y coordinate/counter

Ports:
- clk  in  1  pixel-slot clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  run request; level-sensitive
- pix_req  out  1  one-cycle request for pixel (pix_x, pix_y)
- pix_x  out  X_W  requested column; 0 when pix_req low
- pix_y  out  Y_W  requested line; 0 when pix_req low
- pix_data  in  CHANNELS*CH_WIDTH  pixel word; sampled FETCH_LATENCY clocks after pix_req
- lcd_dat  out  CH_WIDTH  serialised sub-pixel data
- lcd_hsync  out  1  horizontal sync
- lcd_vsync  out  1  vertical sync
- lcd_den  out  1  data enable
- frame_start  out  1  one-cycle pulse at counter position (0,0), slot 0
- frame_count  out  16  completed frames, wraps at 65535 -> 0
- busy  out  1  high while the state is not STOPPED

Behaviour:
- Reset (async, any time, including mid-frame):
  - state STOPPED; h_pos, v_pos and slot counters cleared to 0.
  - Delay pipeline cleared; frame_count 0.
  - pix_req 0, pix_x 0, pix_y 0, frame_start 0, lcd_dat 0.
  - lcd_hsync = !HSYNC_POL, lcd_vsync = !VSYNC_POL, lcd_den = !DE_POL.
- Counters:
  - slot runs 0..CHANNELS-1.
  - h_pos advances on slot wrap and runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H_ parameters.
  - v_pos advances on h_pos wrap and runs 0..V_TOTAL-1.
  - Counters advance only in RUNNING/DRAINING. In STOPPED they hold at 0.
- Raw (undelayed) signals:
  - vis = h_pos < H_VISIBLE and v_pos < V_VISIBLE.
  - hs active while H_VISIBLE+H_FRONT <= h_pos < H_VISIBLE+H_FRONT+H_SYNC.
  - vs active by the same rule on v_pos.
  - pix_req = vis and slot==0 and state != STOPPED. Combinational from the counters; pix_x/pix_y = h_pos/v_pos.
- Alignment:
  - Define L = FETCH_LATENCY.
  - At edge L after a pix_req cycle: lcd_dat <= pix_data[top slice], and the remaining slices are loaded into a hold register.
  - The next CHANNELS-1 edges output the next-lower slices in turn.
  - Blanking slots output lcd_dat = 0.
  - hs, vs and vis pass through L+1 register stages, so sync/DE edges coincide with the first and last data byte.
  - With L=0 the total latency is 1 clock.
- State machine:
  - STOPPED -> RUNNING when enable=1. The first counted cycle is (0,0), slot 0, with frame_start=1.
  - RUNNING -> DRAINING when enable=0.
  - DRAINING -> RUNNING when enable returns to 1; the counters are not disturbed.
  - DRAINING -> STOPPED on the frame-wrap edge (last slot, h_pos=H_TOTAL-1, v_pos=V_TOTAL-1) if enable=0.
  - The current frame is always completed. A partial frame is never emitted.
  - After STOPPED, the pipeline flushes over L+1 clocks, then outputs sit at inactive levels.
- frame_count:
  - Increments on every frame-wrap edge while RUNNING or DRAINING, including the wrap that stops the block.
- frame_start:
  - Asserted when state != STOPPED and the counters are at (0,0), slot 0.
- CHANNELS=1: the hold register is unused; every clock is one full pixel.

Test Plan:
- Defaults, enable=1 from reset:
  - hsync period is 1224 clocks, active low for 90 clocks; the first falling edge is at clock 1+340*3.
  - vsync period is 262*1224 clocks, active low for 3*1224.
- pix_data=0x123456 held, L=0: on a visible pixel, lcd_dat = 0x12, 0x34, 0x56 on three consecutive clocks with lcd_den low. In blanking, lcd_dat = 0x00.
- FETCH_LATENCY=2:
  - The source returns the value {pix_x[7:0], pix_y[7:0], 8'hA5} exactly 2 clocks after pix_req.
  - Column 5 of line 7 must appear as 05,07,A5, aligned with DE, for every pixel.
- enable dropped at line 100:
  - The frame completes, then busy falls and frame_count goes 0 -> 1.
  - No further pix_req; syncs stay inactive.
  - Re-enable restarts at (0,0) with a frame_start pulse.
- enable low then high within the same frame: there is no stop and no counter discontinuity.
- resetn pulsed low mid-line: all outputs take their reset values immediately (asynchronously). After release with enable=1, timing restarts from (0,0).
- CHANNELS=1, CH_WIDTH=16, HSYNC_POL=1, DE_POL=1: 408-clock lines, a high hsync pulse and a high DE over 320 clocks, each carrying the full pix_data.
